// File: rtl/buffer_pkg.sv
// Shared widths, parameter-legality check and sliding-window default for the buffer sequencer.
// Optional feature macro: BUF_SLIDE_EN (overlapping read windows with a per-pop stride).
package buffer_pkg;

    // Pointer width never drops below 1 bit so DEPTH=1 still has a legal address port.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

`ifdef BUF_SLIDE_EN
    localparam bit SLIDE_EN = 1'b1;
`else
    localparam bit SLIDE_EN = 1'b0;
`endif

endpackage

`define BUF_PARAM_CHECK(D, PW, PR) \
    if ((D) < 1) begin : g_bad_depth \
        $error("buffer_ctrl: DEPTH must be >= 1"); \
    end \
    if ((PW) < 1 || (PW) > (D)) begin : g_bad_par_write \
        $error("buffer_ctrl: PAR_WRITE must be in 1..DEPTH"); \
    end \
    if ((PR) < 1 || (PR) > (D)) begin : g_bad_par_read \
        $error("buffer_ctrl: PAR_READ must be in 1..DEPTH"); \
    end

// File: rtl/buffer_ctrl_ptr_mod_add.sv
// Circular pointer advance: res = (ptr + inc) mod DEPTH, with inc <= DEPTH.
// Power-of-two depths truncate; other depths use one conditional subtract.
module ptr_mod_add #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int INC_WIDTH  = 3
) (
    input  logic [ADDR_WIDTH-1:0] ptr,
    input  logic [INC_WIDTH-1:0]  inc,
    output logic [ADDR_WIDTH-1:0] res
);
    localparam int SW = ADDR_WIDTH + 1;

    logic [SW-1:0] sum;

    assign sum = {1'b0, ptr} + SW'(inc);

    generate
        if (DEPTH == (1 << ADDR_WIDTH)) begin : g_pow2
            assign res = ADDR_WIDTH'(sum);
        end else begin : g_general
            assign res = (sum >= SW'(DEPTH)) ? ADDR_WIDTH'(sum - SW'(DEPTH)) : ADDR_WIDTH'(sum);
        end
    endgenerate

endmodule

// File: rtl/buffer_ctrl.sv
// Circular-FIFO sequencer: owns write/read pointers and occupancy, drives Buffer wen/waddr/raddr.
// Optional feature macro: BUF_SLIDE_EN adds rd_stride for overlapping read windows.
module buffer_ctrl
    import buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PAR_WRITE  = 1,
    parameter int PAR_READ   = 1,
    parameter int ADDR_WIDTH = addr_w(DEPTH),
    parameter int CNT_WIDTH  = cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  rd_valid,
    input  logic                  rd_ready,
`ifdef BUF_SLIDE_EN
    input  logic [CNT_WIDTH-1:0]  rd_stride,
`endif
    output logic                  buf_wen,
    output logic [ADDR_WIDTH-1:0] buf_waddr,
    output logic [ADDR_WIDTH-1:0] buf_raddr,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  full,
    output logic                  empty
);
    `BUF_PARAM_CHECK(DEPTH, PAR_WRITE, PAR_READ)

    localparam logic [CNT_WIDTH-1:0] PW_C     = CNT_WIDTH'(PAR_WRITE);
    localparam logic [CNT_WIDTH-1:0] PR_C     = CNT_WIDTH'(PAR_READ);
    localparam logic [CNT_WIDTH-1:0] WR_LIMIT = CNT_WIDTH'(DEPTH - PAR_WRITE);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, wptr_nxt;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d, rptr_nxt;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH:0]    count_ext;
    logic [CNT_WIDTH-1:0]  adv;
    logic [CNT_WIDTH-1:0]  winc, rinc;
    logic                  push, pop;

    // Handshakes depend only on the registered count, so a pop never frees space in the same cycle.
    assign wr_ready = (count_q <= WR_LIMIT);
    assign rd_valid = (count_q >= PR_C);
    assign push     = wr_valid & wr_ready & ~clr;
    assign pop      = rd_valid & rd_ready & ~clr;

`ifdef BUF_SLIDE_EN
    assign adv = (rd_stride > PR_C) ? PR_C : rd_stride;
`else
    assign adv = PR_C;
`endif

    assign winc = push ? PW_C : '0;
    assign rinc = pop ? adv : '0;

    ptr_mod_add #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INC_WIDTH  (CNT_WIDTH)
    ) u_wptr_add (
        .ptr (wptr_q),
        .inc (winc),
        .res (wptr_nxt)
    );

    ptr_mod_add #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .INC_WIDTH  (CNT_WIDTH)
    ) u_rptr_add (
        .ptr (rptr_q),
        .inc (rinc),
        .res (rptr_nxt)
    );

    always_comb begin
        count_ext = {1'b0, count_q} + {1'b0, winc} - {1'b0, rinc};
        wptr_d    = wptr_nxt;
        rptr_d    = rptr_nxt;
        count_d   = count_ext[CNT_WIDTH] ? '0 : count_ext[CNT_WIDTH-1:0];
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign buf_wen   = push;
    assign buf_waddr = wptr_q;
    assign buf_raddr = rptr_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);

endmodule
